// File: rtl/nl_vc_input_requester_pkg.sv
// Shared router types: one-hot output port, flit layout and the error-flag bit map
// used by the input requester, the VC allocator and the crossbar.
package NL_package;

    localparam int NL_NP = 7;
    localparam int NL_DW = 32;

    typedef logic [NL_NP-1:0] output_port_t;

    typedef struct packed {
        logic [NL_DW-1:0] data;
        output_port_t     port;
    } flit_t;

    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_NO_REQ   = 1;
    localparam int ERR_MULTI    = 2;
    localparam int ERR_W        = 3;

endpackage

// File: rtl/nl_vc_input_requester_fifo.sv
// Synchronous single-clock FIFO holding the flits of one virtual channel.
// A pop frees its slot at the same edge, so push+pop on a full FIFO is accepted.
module nl_vc_fifo #(
    parameter int W     = 39,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/nl_vc_input_requester.sv
// Input-port VC buffering: per-VC FIFOs, allocator request/port presentation,
// grant-driven pop with registered crossbar flit, upstream credit and sticky error flags.
module nl_vc_input_requester
    import NL_package::*;
#(
    parameter int NP    = NL_NP,
    parameter int NV    = 2,
    parameter int DEPTH = 4,
    parameter int DW    = NL_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flit_in_valid,
    input  logic [$clog2(NV)-1:0]    flit_in_vc,
    input  logic [DW-1:0]            flit_in_data,
    input  logic [NP-1:0]            flit_in_port,
    output logic [NV-1:0]            req,
    output logic [NV-1:0][NP-1:0]    output_port,
    input  logic [NV-1:0]            grant,
    output logic                     flit_out_valid,
    output logic [DW-1:0]            flit_out_data,
    output logic [NP-1:0]            flit_out_port,
    output logic                     credit_out_valid,
    output logic [$clog2(NV)-1:0]    credit_out_vc,
    output logic [ERR_W-1:0]         err
);

    localparam int VW = $clog2(NV);
    localparam int FW = DW + NP;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [FW-1:0] head [NV];
    logic [CW-1:0] count [NV];
    logic [NV-1:0] empty;
    logic [NV-1:0] full;
    logic [NV-1:0] push;
    logic [NV-1:0] pop;

    logic [NV-1:0] valid_grant;
    logic [VW-1:0] pop_idx;
    logic          pop_any;
    logic [FW-1:0] pop_flit;
    logic [ERR_W-1:0] err_set;

    for (genvar v = 0; v < NV; v++) begin : g_vc
        assign push[v] = flit_in_valid && (flit_in_vc == VW'(v));

        nl_vc_fifo #(
            .W     (FW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[v]),
            .pop   (pop[v]),
            .din   ({flit_in_data, flit_in_port}),
            .head  (head[v]),
            .empty (empty[v]),
            .full  (full[v]),
            .count (count[v])
        );
    end

    // Requests and ports come only from registered FIFO state, so a grant never loops back into req.
    always_comb begin
        req         = '0;
        output_port = '0;
        for (int v = 0; v < NV; v++) begin
            req[v] = !empty[v];
            if (count[v] != '0) output_port[v] = head[v][NP-1:0];
        end
    end

    // Lowest-index requested grant wins; a multi-hot grant still pops exactly one VC.
    always_comb begin
        valid_grant = grant & req;
        pop_any     = |valid_grant;
        pop_idx     = '0;
        pop         = '0;
        for (int v = NV - 1; v >= 0; v--) begin
            if (valid_grant[v]) pop_idx = VW'(v);
        end
        if (pop_any) pop[pop_idx] = 1'b1;
        pop_flit = head[pop_idx];
    end

    // A simultaneous pop on the target VC frees a slot, so only a push without it overflows.
    always_comb begin
        err_set               = '0;
        err_set[ERR_OVERFLOW] = flit_in_valid && full[flit_in_vc] && !pop[flit_in_vc];
        err_set[ERR_NO_REQ]   = |(grant & ~req);
        err_set[ERR_MULTI]    = (grant & (grant - NV'(1))) != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_out_valid   <= 1'b0;
            flit_out_data    <= '0;
            flit_out_port    <= '0;
            credit_out_valid <= 1'b0;
            credit_out_vc    <= '0;
            err              <= '0;
        end else begin
            flit_out_valid   <= pop_any;
            credit_out_valid <= pop_any;
            if (pop_any) begin
                flit_out_data <= pop_flit[FW-1:NP];
                flit_out_port <= pop_flit[NP-1:0];
                credit_out_vc <= pop_idx;
            end
            err <= err | err_set;
        end
    end

endmodule
